// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch/issue stage: drives the instruction-memory read port,
// holds the PC and presents the latched instruction word to decode.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              halt,
    input  logic              go,
    output logic [31:0]       instr,
    output logic [5:0]        op_code,
    output logic [5:0]        func,
    output logic [31:0]       pc_out,
    output logic [31:0]       pc_plus4,
    output logic              instr_valid,
    output logic              halted
);

    typedef enum logic [1:0] {
        FETCH,
        LOAD,
        ISSUE,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic        armed_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q;
    logic [31:0] pc_out_q;
    logic        ld_en;
    logic        unused_rpc_lsb;

    // Reset parks in FETCH with the read port idle; armed_q lets the first real
    // fetch start on the first clock edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q     <= '0;
            pc_out_q <= '0;
        end else if (ld_en) begin
            ir_q     <= imem_rdata;
            pc_out_q <= pc_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_en     = 1'b0;
        ld_en       = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state_q)
            FETCH: begin
                imem_en = armed_q;
                if (armed_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld_en   = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                instr_valid = 1'b1;
                // Halt wins over redirect so execution resumes after the syscall.
                if (!stall) begin
                    if (halt) begin
                        pc_d    = pc_plus4;
                        state_d = HALT;
                    end else begin
                        pc_d    = redirect ? {redirect_pc[31:2], 2'b00} : pc_plus4;
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
                if (go) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem_addr      = pc_q[ADDR_W+1:2];
    assign instr          = ir_q;
    assign op_code        = ir_q[31:26];
    assign func           = ir_q[5:0];
    assign pc_out         = pc_out_q;
    assign pc_plus4       = pc_out_q + 32'd4;
    assign unused_rpc_lsb = ^redirect_pc[1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a controller-side driver predicts the PC
// sequence from the fetch rules, a monitor compares every issued instruction.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        go = 1'b0;

    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr, pc_out, pc_plus4;
    logic [5:0]  op_code, func;
    logic        instr_valid, halted;

    logic        w_en;
    logic [9:0]  w_addr;
    logic [31:0] w_rdata = '0;
    logic [31:0] w_instr, w_pc_out, w_pc_plus4;
    logic [5:0]  w_op_code, w_func;
    logic        w_valid, w_halted;
    logic        w_tie = 1'b0;
    logic [31:0] w_tie32 = '0;

    logic [31:0] mem [1024];
    logic [31:0] sb_q [$];
    logic [31:0] model_pc;
    logic        sb_en = 1'b0;
    logic        exp_halt = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(10), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .go(go), .instr(instr),
        .op_code(op_code), .func(func), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .halted(halted)
    );

    instr_fetch_unit #(.ADDR_W(10), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem_en(w_en), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .stall(w_tie), .redirect(w_tie),
        .redirect_pc(w_tie32), .halt(w_tie), .go(w_tie), .instr(w_instr),
        .op_code(w_op_code), .func(w_func), .pc_out(w_pc_out), .pc_plus4(w_pc_plus4),
        .instr_valid(w_valid), .halted(w_halted)
    );

    // Synchronous-read instruction memories: data appears the cycle after the enable.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
        if (w_en)    w_rdata    <= mem[w_addr];
    end

    function automatic logic [31:0] ref_word(input logic [31:0] pc);
        logic [9:0] idx;
        idx = pc[11:2];
        return mem[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got timeout expected DUT event", name);
    endtask

    // Controller model: answers one ISSUE, predicting the next PC from the chosen action.
    task automatic issue_one(input int unsigned k, input bit h, input bit r,
                             input logic [31:0] tgt, input int unsigned hw);
        int unsigned t;
        t = 0;
        while (!instr_valid && t < 12) begin
            redirect    = 1'($urandom_range(0, 1));
            halt        = 1'($urandom_range(0, 1));
            redirect_pc = $urandom;
            @(negedge clk);
            t++;
        end
        if (!instr_valid) begin
            fail_now("wait_issue");
            return;
        end
        for (int unsigned i = 0; i < k; i++) begin
            stall       = 1'b1;
            redirect    = 1'($urandom_range(0, 1));
            halt        = 1'($urandom_range(0, 1));
            go          = 1'($urandom_range(0, 1));
            redirect_pc = $urandom;
            @(negedge clk);
        end
        stall       = 1'b0;
        halt        = h;
        redirect    = r;
        redirect_pc = tgt;
        go          = 1'b0;
        if (h || !r) model_pc = model_pc + 32'd4;
        else         model_pc = {tgt[31:2], 2'b00};
        sb_q.push_back(model_pc);
        @(negedge clk);
        halt     = 1'b0;
        redirect = 1'b0;
        if (h) begin
            exp_halt = 1'b1;
            for (int unsigned i = 0; i < hw; i++) begin
                stall       = 1'($urandom_range(0, 1));
                redirect    = 1'($urandom_range(0, 1));
                halt        = 1'($urandom_range(0, 1));
                redirect_pc = $urandom;
                @(negedge clk);
            end
            stall    = 1'b0;
            redirect = 1'b0;
            halt     = 1'b0;
            go       = 1'b1;
            @(negedge clk);
            go       = 1'b0;
            exp_halt = 1'b0;
        end
    endtask

    task automatic issue_random();
        int unsigned k;
        k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
        issue_one(k, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                  $urandom, $urandom_range(0, 4));
    endtask

    initial begin : monitor
        logic [31:0] p;
        logic [31:0] w;
        logic [9:0]  idx;
        forever begin
            @(negedge clk);
            #1;
            if (sb_en && rst_n) begin
                check("halted", 32'(halted), 32'(exp_halt));
                if (exp_halt) begin
                    check("halt_valid", 32'(instr_valid), 32'd0);
                    check("halt_imem_en", 32'(imem_en), 32'd0);
                end
                if (imem_en) begin
                    if (sb_q.size() == 0) fail_now("fetch_unexpected");
                    else begin
                        p   = sb_q[0];
                        idx = p[11:2];
                        check("imem_addr", 32'(imem_addr), 32'(idx));
                    end
                end
                if (instr_valid) begin
                    if (sb_q.size() == 0) fail_now("issue_unexpected");
                    else begin
                        p = sb_q[0];
                        w = ref_word(p);
                        check("pc_out", pc_out, p);
                        check("instr", instr, w);
                        check("op_code", 32'(op_code), 32'(w[31:26]));
                        check("func", 32'(func), 32'(w[5:0]));
                        check("pc_plus4", pc_plus4, p + 32'd4);
                        if (!stall) void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int unsigned d_k  [7] = '{0, 4, 0, 0, 0, 0, 2};
        bit          d_h  [7] = '{0, 0, 0, 1, 0, 0, 1};
        bit          d_r  [7] = '{0, 0, 1, 1, 1, 0, 0};
        logic [31:0] d_t  [7] = '{32'h0, 32'h0, 32'h0000_0043, 32'h0000_0200,
                                  32'hFFFF_FFFF, 32'h0, 32'h0};
        int unsigned d_hw [7] = '{0, 0, 0, 5, 0, 0, 1};
        int unsigned t;
        logic [31:0] w;

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < 16; i++) mem[i] = {6'd0, 20'(i), 6'd32};

        repeat (3) @(negedge clk);
        check("rst_instr", instr, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_imem_en", 32'(imem_en), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_wrap_addr", 32'(w_addr), 32'd1023);

        model_pc = 32'h0;
        sb_q.push_back(model_pc);
        sb_en = 1'b1;
        rst_n = 1'b1;

        fork
            begin : wrap_chk
                #1;
                check("arm_imem_en", 32'(w_en), 32'd0);
                t = 0;
                while (!w_en && t < 8) begin @(negedge clk); #1; t++; end
                if (!w_en) fail_now("wrap_fetch1");
                else check("wrap_addr1", 32'(w_addr), 32'd1023);
                t = 0;
                while (!w_valid && t < 8) begin @(negedge clk); #1; t++; end
                if (!w_valid) fail_now("wrap_issue");
                else begin
                    w = mem[1023];
                    check("wrap_pc_out", w_pc_out, 32'hFFFF_FFFC);
                    check("wrap_pc_plus4", w_pc_plus4, 32'd0);
                    check("wrap_instr", w_instr, w);
                end
                t = 0;
                while (!w_en && t < 8) begin @(negedge clk); #1; t++; end
                if (!w_en) fail_now("wrap_fetch2");
                else check("wrap_addr2", 32'(w_addr), 32'd0);
            end
            begin : stimulus
                for (int i = 0; i < 7; i++) issue_one(d_k[i], d_h[i], d_r[i], d_t[i], d_hw[i]);
                repeat (60) issue_random();
            end
        join

        // Asynchronous reset landing in the middle of a LOAD cycle.
        t = 0;
        while (!imem_en && t < 12) begin @(negedge clk); t++; end
        if (!imem_en) fail_now("wait_fetch_for_reset");
        sb_en = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_instr", instr, 32'd0);
        check("midrst_pc_out", pc_out, 32'd0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_halted", 32'(halted), 32'd0);
        check("midrst_imem_en", 32'(imem_en), 32'd0);
        check("midrst_imem_addr", 32'(imem_addr), 32'd0);
        sb_q.delete();
        exp_halt = 1'b0;
        model_pc = 32'h0;
        sb_q.push_back(model_pc);
        @(negedge clk);
        rst_n = 1'b1;
        sb_en = 1'b1;
        #1;
        check("postrst_valid", 32'(instr_valid), 32'd0);
        check("postrst_imem_en", 32'(imem_en), 32'd0);
        repeat (12) issue_random();

        @(negedge clk);
        #2;
        check("sb_pending", sb_q.size(), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
